// File: rtl/bsg_gateway_chip_start_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bsg_gateway_chip_start_sequencer
// Brief    : Releases gateway link and core-complex resets in order once
//            tag-trace replay reports done; flags a replay watchdog timeout.
// Revision : 1.0
// ============================================================================
module bsg_gateway_chip_start_sequencer #(
    parameter int sync_stages_p        = 2,
    parameter int link_settle_cycles_p = 32,
    parameter int core_settle_cycles_p = 16,
    parameter int timeout_cycles_p     = 1048576,
    parameter int run_ctr_width_p      = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       tag_trace_done_i,
    output logic                       link_reset_o,
    output logic                       core_reset_o,
    output logic                       run_o,
    output logic                       timeout_o,
    output logic [2:0]                 state_o,
    output logic [run_ctr_width_p-1:0] run_cycles_o
);

    localparam int c_max_settle = (link_settle_cycles_p > core_settle_cycles_p)
                                ? link_settle_cycles_p : core_settle_cycles_p;
    localparam int c_max_count  = (c_max_settle > timeout_cycles_p)
                                ? c_max_settle : timeout_cycles_p;
    localparam int c_ctr_w      = $clog2(c_max_count + 1);

    localparam logic [c_ctr_w-1:0] c_link_last = c_ctr_w'(link_settle_cycles_p - 1);
    localparam logic [c_ctr_w-1:0] c_core_last = c_ctr_w'(core_settle_cycles_p - 1);
    localparam logic [c_ctr_w-1:0] c_tmo_last  = c_ctr_w'(timeout_cycles_p - 1);
    localparam logic [c_ctr_w-1:0] c_ctr_one   = c_ctr_w'(1);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_link = 3'd1;
    localparam logic [2:0] c_st_core = 3'd2;
    localparam logic [2:0] c_st_run  = 3'd3;
    localparam logic [2:0] c_st_tmo  = 3'd4;

    localparam logic [run_ctr_width_p-1:0] c_run_max = {run_ctr_width_p{1'b1}};
    localparam logic [run_ctr_width_p-1:0] c_run_one = run_ctr_width_p'(1);

    generate
        if (sync_stages_p < 2) begin : g_chk_sync
            $error("sync_stages_p must be at least 2");
        end
        if (link_settle_cycles_p < 1) begin : g_chk_link
            $error("link_settle_cycles_p must be at least 1");
        end
        if (core_settle_cycles_p < 1) begin : g_chk_core
            $error("core_settle_cycles_p must be at least 1");
        end
        if (timeout_cycles_p < 2) begin : g_chk_tmo
            $error("timeout_cycles_p must be at least 2");
        end
        if (run_ctr_width_p < 1) begin : g_chk_run_w
            $error("run_ctr_width_p must be at least 1");
        end
    endgenerate

    logic [sync_stages_p-1:0]   sync_q,       sync_d;
    logic [2:0]                 state_q,      state_d;
    logic [c_ctr_w-1:0]         ctr_q,        ctr_d;
    logic                       link_reset_q, link_reset_d;
    logic                       core_reset_q, core_reset_d;
    logic                       run_q,        run_d;
    logic                       timeout_q,    timeout_d;
    logic [run_ctr_width_p-1:0] run_cycles_q, run_cycles_d;
    logic                       w_done_sync;

    assign w_done_sync = sync_q[sync_stages_p-1];

    always_comb begin
        sync_d = {sync_q[sync_stages_p-2:0], tag_trace_done_i};
    end

    // Done is only sampled in IDLE, so a drop after LINK entry cannot stall the sequence.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q + c_ctr_one;
        case (state_q)
            c_st_idle: begin
                if (w_done_sync) begin
                    state_d = c_st_link;
                end else if (ctr_q == c_tmo_last) begin
                    state_d = c_st_tmo;
                end
            end
            c_st_link: begin
                if (ctr_q == c_link_last) begin
                    state_d = c_st_core;
                end
            end
            c_st_core: begin
                if (ctr_q == c_core_last) begin
                    state_d = c_st_run;
                end
            end
            c_st_run: begin
                ctr_d = '0;
            end
            c_st_tmo: begin
                ctr_d = '0;
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
        if (state_d != state_q) begin
            ctr_d = '0;
        end
    end

    // Outputs are registered from the next state so they switch with state_o.
    always_comb begin
        link_reset_d = (state_d == c_st_idle) || (state_d == c_st_link) || (state_d == c_st_tmo);
        core_reset_d = (state_d != c_st_run);
        run_d        = (state_d == c_st_run);
        timeout_d    = (state_d == c_st_tmo);
        run_cycles_d = run_cycles_q;
        if ((state_q == c_st_run) && (run_cycles_q != c_run_max)) begin
            run_cycles_d = run_cycles_q + c_run_one;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q       <= '0;
            state_q      <= c_st_idle;
            ctr_q        <= '0;
            link_reset_q <= 1'b1;
            core_reset_q <= 1'b1;
            run_q        <= 1'b0;
            timeout_q    <= 1'b0;
            run_cycles_q <= '0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            ctr_q        <= ctr_d;
            link_reset_q <= link_reset_d;
            core_reset_q <= core_reset_d;
            run_q        <= run_d;
            timeout_q    <= timeout_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    assign link_reset_o = link_reset_q;
    assign core_reset_o = core_reset_q;
    assign run_o        = run_q;
    assign timeout_o    = timeout_q;
    assign state_o      = state_q;
    assign run_cycles_o = run_cycles_q;

endmodule
`default_nettype wire
